tank_bullet_engine: RTL and testbench
=====================================

Name: tank_bullet_engine

Overview:
- Per-player projectile engine, directly upstream of the VGA compositor.
- Turns the fire button, joystick direction and current tank position into one bullet's position, advanced once per frame.
- Produces a per-pixel hit flag, `isInBullet`, that the compositor uses to overlay the bullet on the background and tank sprite.
- All state updates on the frame tick, derived from `screenEnd`, so bullet motion matches tank motion.

Parameters:
- VIDEO_WIDTH, 640, visible width in pixels
- VIDEO_HEIGHT, 480, visible height in pixels
- SPRITE_SIZE, 64, tank sprite edge in pixels
- BULLET_SIZE, 4, square bullet edge in pixels
- BULLET_SPEED, 6, pixels moved per frame tick
- COOLDOWN_FRAMES, 30, frame ticks after retirement before the next shot is allowed

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-low reset
- screenEnd  in  1  frame-boundary strobe from the timing generator (may last several clk cycles)
- fire  in  1  raw fire button, asynchronous
- dirUp, dirDown, dirLeft, dirRight  in  1 each  raw joystick/button directions, asynchronous
- tankX  in  10  tank top-left X
- tankY  in  11  tank top-left Y
- x  in  10  current scan X
- y  in  11  current scan Y
- bulletX  out  10  bullet top-left X
- bulletY  out  11  bullet top-left Y
- bulletActive  out  1  bullet in flight
- isInBullet  out  1  scan pixel (x,y) lies inside the active bullet
- cooldownBusy  out  1  high while in COOLDOWN

Behaviour:
Reset values:
- Clock is `clk`; reset is synchronous and active-low.
- On reset low at a clk edge: state=IDLE, bulletX=0, bulletY=0, bulletActive=0, isInBullet=0, cooldownBusy=0, facing=UP, fire pending=0, cooldown count=0.
- Reset mid-flight or mid-cooldown aborts immediately to these values.

Input conditioning:
- `fire` and the four directions each pass through a 2-flop synchronizer.
- Frame tick = one-clk pulse on the rising edge of synchronized `screenEnd`.
- Fire pending is set on the rising edge of synchronized `fire`.
- Fire pending is cleared on every tick, whether the shot is consumed or discarded.
- Facing register updates on each tick: priority Up > Down > Left > Right; with no direction asserted it holds its value.

State machine (all transitions only on tick):
- IDLE:
  - Fire pending → spawn: bulletX = tankX + (SPRITE_SIZE−BULLET_SIZE)/2, bulletY = tankY + (SPRITE_SIZE−BULLET_SIZE)/2.
  - Latch the current facing as the bullet direction; set bulletActive=1; go to FLIGHT.
  - The spawn uses the facing value before that same tick's update.
- FLIGHT: retire if the next step would leave the screen, otherwise move by BULLET_SPEED.
  - UP: retire if bulletY < BULLET_SPEED.
  - DOWN: retire if bulletY + BULLET_SIZE + BULLET_SPEED > VIDEO_HEIGHT.
  - LEFT: retire if bulletX < BULLET_SPEED.
  - RIGHT: retire if bulletX + BULLET_SIZE + BULLET_SPEED > VIDEO_WIDTH.
  - Retire: bulletActive=0, bulletX/bulletY hold; load count=COOLDOWN_FRAMES; go to COOLDOWN, or straight to IDLE if COOLDOWN_FRAMES=0.
  - Fire during FLIGHT is discarded.
- COOLDOWN:
  - cooldownBusy=1; count decrements on each tick.
  - On the tick where count reaches 0, go to IDLE.
  - Fire during COOLDOWN is discarded.

Arithmetic and output timing:
- All comparisons are unsigned, computed at 12 bits so nothing wraps.
- isInBullet is registered, one clk after (x,y): bulletActive && bulletX ≤ x < bulletX+BULLET_SIZE && bulletY ≤ y < bulletY+BULLET_SIZE. This matches the one-clk read latency of the sprite RAM.

Optional Feature:
- Macro: BULLET_AUTOFIRE_EN.
- Defined: in IDLE, synchronized `fire` held high at a tick spawns a bullet; no edge is needed. Holding the button re-fires every time cooldown ends.
- Undefined: only a new rising edge of `fire` fires (edge-latched pending as above).

Test Plan:
- Spawn and UP flight: tank (100,200), no direction, fire pulse → next tick bullet (130,230), active=1. After each further tick bulletY = 224, 218, …; it stops at 2 after 38 moves. The 39th tick retires: active=0, cooldownBusy=1.
- RIGHT flight near edge: tank (570,100), dirRight held, fire → bulletX 600, then 606 … 636 over 6 ticks; the 7th tick retires with bulletX=636.
- Cooldown: after retirement fire every frame → no spawn for 30 ticks; cooldownBusy drops on the 30th tick. A fire before the following tick spawns on it.
- Pixel flag: bullet at (130,230); scan (131,231) → isInBullet=1 one clk later; scan (134,231) and (129,230) → 0; bulletActive=0 → always 0.
- Fire in flight / reset mid-flight: second fire during FLIGHT → position unchanged, no respawn. Reset low for one clk mid-flight → all outputs 0, IDLE, facing=UP.
- Long screenEnd: screenEnd high for 4 clk → exactly one 6-pixel move.

Source files
------------

// File: rtl/tank_bullet_engine.sv
// Single-bullet projectile engine: spawns from the tank, flies one step per frame tick, then cools down.
// Optional macro BULLET_AUTOFIRE_EN: a held fire button re-fires without needing a fresh press.
module tank_bullet_engine #(
    parameter int VIDEO_WIDTH     = 640,
    parameter int VIDEO_HEIGHT    = 480,
    parameter int SPRITE_SIZE     = 64,
    parameter int BULLET_SIZE     = 4,
    parameter int BULLET_SPEED    = 6,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screenEnd,
    input  logic        fire,
    input  logic        dirUp,
    input  logic        dirDown,
    input  logic        dirLeft,
    input  logic        dirRight,
    input  logic [9:0]  tankX,
    input  logic [10:0] tankY,
    input  logic [9:0]  x,
    input  logic [10:0] y,
    output logic [9:0]  bulletX,
    output logic [10:0] bulletY,
    output logic        bulletActive,
    output logic        isInBullet,
    output logic        cooldownBusy
);

    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [9:0]  OFF_X    = 10'((SPRITE_SIZE - BULLET_SIZE) / 2);
    localparam logic [10:0] OFF_Y    = 11'((SPRITE_SIZE - BULLET_SIZE) / 2);
    localparam logic [9:0]  STEP_X   = 10'(BULLET_SPEED);
    localparam logic [10:0] STEP_Y   = 11'(BULLET_SPEED);
    localparam logic [11:0] SPEED12  = 12'(BULLET_SPEED);
    localparam logic [11:0] SIZE12   = 12'(BULLET_SIZE);
    localparam logic [11:0] WIDTH12  = 12'(VIDEO_WIDTH);
    localparam logic [11:0] HEIGHT12 = 12'(VIDEO_HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_COOLDOWN} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t     state, state_n;
    dir_t       facing, facing_n, bullet_dir, bullet_dir_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic       pending, pending_n;
    logic [9:0] bx_n;
    logic [10:0] by_n;
    logic       act_n, hit_n;

    // Input synchronizers: bit 4 fire, 3 up, 2 down, 1 left, 0 right
    logic [4:0] sync_p0, sync_p1;
    logic       fire_p2;
    logic       se_p0, se_p1, se_p2;
    logic       tick, fire_rise, fire_req, retire;

    assign tick      = se_p1 & ~se_p2;
    assign fire_rise = sync_p1[4] & ~fire_p2;

`ifdef BULLET_AUTOFIRE_EN
    assign fire_req = sync_p1[4] | pending;
`else
    assign fire_req = pending | fire_rise;
`endif

    assign cooldownBusy = (state == S_COOLDOWN);

    logic [11:0] bx12, by12, x12, y12;
    assign bx12 = {2'b00, bulletX};
    assign by12 = {1'b0, bulletY};
    assign x12  = {2'b00, x};
    assign y12  = {1'b0, y};

    always_comb begin
        retire = 1'b0;
        unique case (bullet_dir)
            DIR_UP:    retire = by12 < SPEED12;
            DIR_DOWN:  retire = (by12 + SIZE12 + SPEED12) > HEIGHT12;
            DIR_LEFT:  retire = bx12 < SPEED12;
            DIR_RIGHT: retire = (bx12 + SIZE12 + SPEED12) > WIDTH12;
            default:   retire = 1'b0;
        endcase
    end

    always_comb begin
        state_n      = state;
        facing_n     = facing;
        bullet_dir_n = bullet_dir;
        cnt_n        = cnt;
        pending_n    = pending;
        bx_n         = bulletX;
        by_n         = bulletY;
        act_n        = bulletActive;

        hit_n = bulletActive && (x12 >= bx12) && (x12 < bx12 + SIZE12)
                             && (y12 >= by12) && (y12 < by12 + SIZE12);

        if (fire_rise)
            pending_n = 1'b1;

        if (tick) begin
            // Any shot request not taken on this tick is dropped
            pending_n = 1'b0;

            if (sync_p1[3])      facing_n = DIR_UP;
            else if (sync_p1[2]) facing_n = DIR_DOWN;
            else if (sync_p1[1]) facing_n = DIR_LEFT;
            else if (sync_p1[0]) facing_n = DIR_RIGHT;

            unique case (state)
                S_IDLE: begin
                    if (fire_req) begin
                        bx_n         = tankX + OFF_X;
                        by_n         = tankY + OFF_Y;
                        bullet_dir_n = facing;
                        act_n        = 1'b1;
                        state_n      = S_FLIGHT;
                    end
                end
                S_FLIGHT: begin
                    if (retire) begin
                        act_n = 1'b0;
                        cnt_n = CNT_W'(COOLDOWN_FRAMES);
                        state_n = (COOLDOWN_FRAMES == 0) ? S_IDLE : S_COOLDOWN;
                    end else begin
                        unique case (bullet_dir)
                            DIR_UP:    by_n = bulletY - STEP_Y;
                            DIR_DOWN:  by_n = bulletY + STEP_Y;
                            DIR_LEFT:  bx_n = bulletX - STEP_X;
                            DIR_RIGHT: bx_n = bulletX + STEP_X;
                            default:   ;
                        endcase
                    end
                end
                S_COOLDOWN: begin
                    cnt_n = cnt - 1'b1;
                    if (cnt <= CNT_W'(1))
                        state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_p0      <= '0;
            sync_p1      <= '0;
            fire_p2      <= 1'b0;
            se_p0        <= 1'b0;
            se_p1        <= 1'b0;
            se_p2        <= 1'b0;
            state        <= S_IDLE;
            facing       <= DIR_UP;
            bullet_dir   <= DIR_UP;
            cnt          <= '0;
            pending      <= 1'b0;
            bulletX      <= '0;
            bulletY      <= '0;
            bulletActive <= 1'b0;
            isInBullet   <= 1'b0;
        end else begin
            sync_p0      <= {fire, dirUp, dirDown, dirLeft, dirRight};
            sync_p1      <= sync_p0;
            fire_p2      <= sync_p1[4];
            se_p0        <= screenEnd;
            se_p1        <= se_p0;
            se_p2        <= se_p1;
            state        <= state_n;
            facing       <= facing_n;
            bullet_dir   <= bullet_dir_n;
            cnt          <= cnt_n;
            pending      <= pending_n;
            bulletX      <= bx_n;
            bulletY      <= by_n;
            bulletActive <= act_n;
            // Registered to line up with the sprite RAM read latency
            isInBullet   <= hit_n;
        end
    end

endmodule

// File: tb/tb_tank_bullet_engine.sv
// Self-checking bench for tank_bullet_engine: directed scenarios plus randomized frames vs a frame-level model.
module tb_tank_bullet_engine;

    localparam int W     = 640;
    localparam int H     = 480;
    localparam int OFF   = (64 - 4) / 2;
    localparam int BSZ   = 4;
    localparam int SPD   = 6;
    localparam int CDF   = 30;

    logic        clk = 1'b0;
    logic        reset, screenEnd, fire, dirUp, dirDown, dirLeft, dirRight;
    logic [9:0]  tankX, x, bulletX;
    logic [10:0] tankY, y, bulletY;
    logic        bulletActive, isInBullet, cooldownBusy;

    always #5 clk = ~clk;

    tank_bullet_engine dut (
        .clk(clk), .reset(reset), .screenEnd(screenEnd), .fire(fire),
        .dirUp(dirUp), .dirDown(dirDown), .dirLeft(dirLeft), .dirRight(dirRight),
        .tankX(tankX), .tankY(tankY), .x(x), .y(y),
        .bulletX(bulletX), .bulletY(bulletY), .bulletActive(bulletActive),
        .isInBullet(isInBullet), .cooldownBusy(cooldownBusy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level model: mode 0 idle, 1 flying, 2 cooling; direction 0 up, 1 down, 2 left, 3 right
    int m_mode, m_bx, m_by, m_act, m_dir, m_cd, m_face;

    task automatic model_reset();
        m_mode = 0; m_bx = 0; m_by = 0; m_act = 0; m_dir = 0; m_cd = 0; m_face = 0;
    endtask

    task automatic model_tick(input bit fr, input bit u, input bit d, input bit l, input bit r,
                              input int tx, input int ty);
        bit off_screen;
        if (m_mode == 0) begin
            if (fr) begin
                m_bx = tx + OFF; m_by = ty + OFF; m_dir = m_face; m_act = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            case (m_dir)
                0: off_screen = (m_by - SPD) < 0;
                1: off_screen = (m_by + SPD + BSZ) > H;
                2: off_screen = (m_bx - SPD) < 0;
                default: off_screen = (m_bx + SPD + BSZ) > W;
            endcase
            if (off_screen) begin
                m_act = 0;
                m_cd = CDF;
                m_mode = (CDF == 0) ? 0 : 2;
            end else begin
                case (m_dir)
                    0: m_by -= SPD;
                    1: m_by += SPD;
                    2: m_bx -= SPD;
                    default: m_bx += SPD;
                endcase
            end
        end else begin
            m_cd--;
            if (m_cd == 0) m_mode = 0;
        end
        if (u) m_face = 0;
        else if (d) m_face = 1;
        else if (l) m_face = 2;
        else if (r) m_face = 3;
    endtask

    function automatic int model_hit(input int px, input int py);
        return (m_act != 0 && px >= m_bx && px < m_bx + BSZ && py >= m_by && py < m_by + BSZ) ? 1 : 0;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".bulletX"}, int'(bulletX), m_bx);
        chk({tag, ".bulletY"}, int'(bulletY), m_by);
        chk({tag, ".active"}, int'(bulletActive), m_act);
        chk({tag, ".busy"}, int'(cooldownBusy), (m_mode == 2) ? 1 : 0);
    endtask

    task automatic pix(input int px, input int py);
        @(negedge clk);
        x = 10'(px); y = 11'(py);
        @(negedge clk);
        chk("pix", int'(isInBullet), model_hit(px, py));
    endtask

    task automatic run_frame(input bit fr, input bit u, input bit d, input bit l, input bit r,
                             input int tx, input int ty, input int se_len, input int npix);
        @(negedge clk);
        tankX = 10'(tx); tankY = 11'(ty);
        dirUp = u; dirDown = d; dirLeft = l; dirRight = r;
        fire = fr;
        repeat (4) @(negedge clk);
        screenEnd = 1'b1;
        repeat (se_len) @(negedge clk);
        screenEnd = 1'b0;
        repeat (4) @(negedge clk);
        model_tick(fr, u, d, l, r, tx, ty);
        check_outputs("frame");
        fire = 1'b0;
        for (int i = 0; i < npix; i++)
            pix(m_bx + $urandom_range(0, 7) - 2 < 0 ? 0 : m_bx + $urandom_range(0, 7) - 2,
                m_by + $urandom_range(0, 7) - 2 < 0 ? 0 : m_by + $urandom_range(0, 7) - 2);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_reset();
        check_outputs("reset");
        chk("reset.inBullet", int'(isInBullet), 0);
        reset = 1'b1;
    endtask

    initial begin
        int moves;
        reset = 1'b0; screenEnd = 1'b0; fire = 1'b0;
        dirUp = 1'b0; dirDown = 1'b0; dirLeft = 1'b0; dirRight = 1'b0;
        tankX = '0; tankY = '0; x = '0; y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("init");
        chk("init.inBullet", int'(isInBullet), 0);
        reset = 1'b1;

        // Spawn from (100,200) facing up, fly to the top edge
        run_frame(0, 0, 0, 0, 0, 100, 200, 1, 0);
        run_frame(1, 0, 0, 0, 0, 100, 200, 1, 0);
        chk("spawn.x", int'(bulletX), 130);
        chk("spawn.y", int'(bulletY), 230);
        chk("spawn.active", int'(bulletActive), 1);
        pix(131, 231); chk("pix.inside", int'(isInBullet), 1);
        pix(134, 231); chk("pix.right", int'(isInBullet), 0);
        pix(129, 230); chk("pix.left", int'(isInBullet), 0);
        moves = 0;
        for (int i = 0; i < 60 && bulletActive; i++) begin
            run_frame(0, 0, 0, 0, 0, 100, 200, 1, 0);
            if (bulletActive) moves++;
        end
        chk("up.moves", moves, 38);
        chk("up.lastY", int'(bulletY), 2);
        chk("up.busy", int'(cooldownBusy), 1);
        pix(130, 2); chk("pix.inactive", int'(isInBullet), 0);

        // Fire on every frame of the cooldown: no spawn, busy drops on the 30th tick
        for (int i = 1; i <= 30; i++) begin
            run_frame(1, 0, 0, 0, 0, 100, 200, 1, 0);
            chk("cd.busy", int'(cooldownBusy), (i < 30) ? 1 : 0);
            chk("cd.active", int'(bulletActive), 0);
        end
        run_frame(1, 0, 0, 0, 0, 100, 200, 1, 0);
        chk("cd.respawn", int'(bulletActive), 1);

        // Long screenEnd gives one step; a second fire in flight is ignored
        run_frame(0, 0, 0, 0, 0, 100, 200, 4, 0);
        chk("long.y", int'(bulletY), 224);
        run_frame(1, 0, 0, 0, 0, 300, 300, 3, 0);
        chk("refire.y", int'(bulletY), 218);
        chk("refire.x", int'(bulletX), 130);
        pulse_reset();

        // Rightward flight near the edge
        run_frame(0, 0, 0, 0, 1, 570, 100, 2, 0);
        run_frame(1, 0, 0, 0, 1, 570, 100, 2, 0);
        chk("right.spawnX", int'(bulletX), 600);
        for (int i = 0; i < 7; i++) run_frame(0, 0, 0, 0, 1, 570, 100, 1, 1);
        chk("right.x", int'(bulletX), 636);
        chk("right.active", int'(bulletActive), 0);
        pulse_reset();

        // Randomized frames
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            run_frame($urandom_range(0, 2) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 576), $urandom_range(0, 416),
                      $urandom_range(1, 4), (m_act != 0) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
